// File: rtl/ram_arbiter.sv
// Three-port arbiter (boot, instruction fetch, data) for a single asynchronous SRAM.
// Define RAM_WAIT_EN to add a WAIT state that stretches the strobe to two cycles.
module ram_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        boot_done,
    input  logic        boot_wr,
    input  logic [15:0] boot_addr,
    input  logic [15:0] boot_data,
    output logic        boot_ack,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_ack,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_ack,
    output logic [17:0] ram_addr,
    output logic [15:0] ram_dout,
    input  logic [15:0] ram_din,
    output logic        ram_dout_oe,
    output logic        ram_ce_n,
    output logic        ram_oe_n,
    output logic        ram_we_n,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
`ifdef RAM_WAIT_EN
    localparam logic [1:0] ST_WAIT   = 2'd2;
`endif
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_BOOT = 2'd1;
    localparam logic [1:0] GNT_MEM  = 2'd2;
    localparam logic [1:0] GNT_IF   = 2'd3;

    logic [1:0]  state;
    logic [1:0]  gnt;
    logic        we_q;
    logic [15:0] addr_q;
    logic [15:0] data_q;
    logic        last_strobe;

    assign ram_addr = {2'b00, addr_q};
    assign ram_dout = data_q;
    assign busy     = (state != ST_IDLE);

    // Read data is taken from the bus on the final cycle the strobe is low.
`ifdef RAM_WAIT_EN
    assign last_strobe = (state == ST_WAIT);
`else
    assign last_strobe = (state == ST_ACCESS);
`endif

    // NOTE: every register here uses non-blocking assignments so all state
    // updates together on the edge; later assignments in the block win.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            gnt         <= GNT_NONE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            ram_ce_n    <= 1'b1;
            ram_oe_n    <= 1'b1;
            ram_we_n    <= 1'b1;
            ram_dout_oe <= 1'b0;
            if_rdata    <= '0;
            mem_rdata   <= '0;
            boot_ack    <= 1'b0;
            mem_ack     <= 1'b0;
            if_ack      <= 1'b0;
        end else begin
            boot_ack <= 1'b0;
            mem_ack  <= 1'b0;
            if_ack   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (boot_wr && !boot_done) begin
                        gnt         <= GNT_BOOT;
                        we_q        <= 1'b1;
                        addr_q      <= boot_addr;
                        data_q      <= boot_data;
                        ram_ce_n    <= 1'b0;
                        ram_we_n    <= 1'b0;
                        ram_dout_oe <= 1'b1;
                        state       <= ST_ACCESS;
                    end else if (mem_req && boot_done) begin
                        gnt         <= GNT_MEM;
                        we_q        <= mem_we;
                        addr_q      <= mem_addr;
                        data_q      <= mem_wdata;
                        ram_ce_n    <= 1'b0;
                        ram_oe_n    <= mem_we;
                        ram_we_n    <= !mem_we;
                        ram_dout_oe <= mem_we;
                        state       <= ST_ACCESS;
                    end else if (if_req && boot_done) begin
                        gnt         <= GNT_IF;
                        we_q        <= 1'b0;
                        addr_q      <= if_addr;
                        ram_ce_n    <= 1'b0;
                        ram_oe_n    <= 1'b0;
                        state       <= ST_ACCESS;
                    end
                end
`ifdef RAM_WAIT_EN
                ST_ACCESS: state <= ST_WAIT;
                ST_WAIT:   state <= ST_DONE;
`else
                ST_ACCESS: state <= ST_DONE;
`endif
                ST_DONE:   state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase

            // Strobes rise as DONE is entered, so DONE always has the bus released.
            if (last_strobe) begin
                ram_ce_n    <= 1'b1;
                ram_oe_n    <= 1'b1;
                ram_we_n    <= 1'b1;
                ram_dout_oe <= 1'b0;
                if (!we_q && gnt == GNT_MEM) mem_rdata <= ram_din;
                if (!we_q && gnt == GNT_IF)  if_rdata  <= ram_din;
                boot_ack <= (gnt == GNT_BOOT);
                mem_ack  <= (gnt == GNT_MEM);
                if_ack   <= (gnt == GNT_IF);
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level memory model.
module tb_ram_arbiter;

`ifdef RAM_WAIT_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        boot_done = 1'b0;
    logic        boot_wr = 1'b0;
    logic [15:0] boot_addr = '0;
    logic [15:0] boot_data = '0;
    logic        boot_ack;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = '0;
    logic [15:0] if_rdata;
    logic        if_ack;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [15:0] mem_wdata = '0;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [17:0] ram_addr;
    logic [15:0] ram_dout;
    logic [15:0] ram_din;
    logic        ram_dout_oe;
    logic        ram_ce_n;
    logic        ram_oe_n;
    logic        ram_we_n;
    logic        busy;

    int total = 0;
    int bad   = 0;

    ram_arbiter dut (
        .clk(clk), .rst(rst), .boot_done(boot_done),
        .boot_wr(boot_wr), .boot_addr(boot_addr), .boot_data(boot_data), .boot_ack(boot_ack),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_din(ram_din), .ram_dout_oe(ram_dout_oe),
        .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n), .busy(busy)
    );

    always #5 clk = ~clk;

    // SRAM contents: unwritten words return a fixed address-derived pattern.
    function automatic logic [15:0] init_val(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    bit [15:0] sram    [0:65535];
    bit        written [0:65535];

    always @(posedge clk) begin
        if (!ram_ce_n && !ram_we_n && ram_dout_oe) begin
            sram[ram_addr[15:0]]    <= ram_dout;
            written[ram_addr[15:0]] <= 1'b1;
        end
    end

    always_comb begin
        ram_din = 16'hDEAD;
        if (!ram_ce_n && !ram_oe_n)
            ram_din = written[ram_addr[15:0]] ? sram[ram_addr[15:0]] : init_val(ram_addr[15:0]);
    end

    // Reference model: what each address should hold after completed writes.
    logic [15:0] model_mem [int];
    logic [15:0] exp_mem_rdata = '0;
    logic [15:0] exp_if_rdata  = '0;

    function automatic logic [15:0] exp_read(input logic [15:0] a);
        return model_mem.exists(int'(a)) ? model_mem[int'(a)] : init_val(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // port: 0 = boot, 1 = mem, 2 = if
    task automatic drive(input int port, input logic we, input logic [15:0] a,
                         input logic [15:0] d, input logic on);
        case (port)
            0: begin boot_wr = on; boot_addr = a; boot_data = d; end
            1: begin mem_req = on; mem_we = we; mem_addr = a; mem_wdata = d; end
            default: begin if_req = on; if_addr = a; end
        endcase
    endtask

    // Called at the negedge of an idle cycle; walks the transaction cycle by cycle.
    task automatic txn(input string tag, input int port, input logic we,
                       input logic [15:0] a, input logic [15:0] d, input bit drop);
        logic [2:0] exp_ack;
        exp_ack = (port == 0) ? 3'b100 : (port == 1) ? 3'b010 : 3'b001;
        drive(port, we, a, d, 1'b1);
        for (int c = 1; c <= LAT + 1; c++) begin
            @(posedge clk); #1;
            if (drop && c == 1) drive(port, !we, ~a, ~d, 1'b0);
            if (!drop && c == LAT + 1) drive(port, we, a, d, 1'b0);
            @(negedge clk);
            if (c < LAT) begin
                check({tag, "_strobe"}, 32'({ram_ce_n, ram_oe_n, ram_we_n, ram_dout_oe}),
                      32'({1'b0, we, !we, we}));
                check({tag, "_addr"}, 32'(ram_addr), 32'({2'b00, a}));
                if (we) check({tag, "_dout"}, 32'(ram_dout), 32'(d));
                check({tag, "_noack"}, 32'({boot_ack, mem_ack, if_ack}), 32'(0));
                check({tag, "_busy"}, 32'(busy), 32'(1));
            end else if (c == LAT) begin
                if (we) model_mem[int'(a)] = d;
                else if (port == 1) exp_mem_rdata = exp_read(a);
                else exp_if_rdata = exp_read(a);
                check({tag, "_done_strobe"},
                      32'({ram_ce_n, ram_oe_n, ram_we_n, ram_dout_oe}), 32'(4'b1110));
                check({tag, "_ack"}, 32'({boot_ack, mem_ack, if_ack}), 32'(exp_ack));
                check({tag, "_mem_rdata"}, 32'(mem_rdata), 32'(exp_mem_rdata));
                check({tag, "_if_rdata"}, 32'(if_rdata), 32'(exp_if_rdata));
            end else begin
                check({tag, "_idle_busy"}, 32'(busy), 32'(0));
                check({tag, "_idle_ack"}, 32'({boot_ack, mem_ack, if_ack}), 32'(0));
            end
        end
    endtask

    logic [15:0] pool [8] = '{16'h0000, 16'h0010, 16'h0123, 16'h4000,
                              16'h8001, 16'hBEEF, 16'hFFFE, 16'hFFFF};

    initial begin
        int a_at, b_at;
        logic [15:0] a_val, b_val;
        bit seen_strobe, seen_ack;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_strobe", 32'({ram_ce_n, ram_oe_n, ram_we_n, ram_dout_oe}), 32'(4'b1110));
        check("rst_addr_dout", 32'({ram_addr, ram_dout}), 32'(0));
        check("rst_rdata", 32'({if_rdata, mem_rdata}), 32'(0));
        check("rst_ack_busy", 32'({boot_ack, mem_ack, if_ack, busy}), 32'(0));
        rst = 1'b0;

        txn("boot_first", 0, 1'b1, 16'h0010, 16'hABCD, 1'b0);
        for (int k = 0; k < 6; k++)
            txn("boot_rand", 0, 1'b1, pool[$urandom_range(0, 7)], 16'($urandom),
                $urandom_range(0, 2) == 0);

        // CPU requests before boot_done must be ignored
        seen_strobe = 0; seen_ack = 0;
        if_req = 1'b1; if_addr = 16'h0123; mem_req = 1'b1; mem_addr = 16'h4000;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            seen_strobe |= !ram_ce_n;
            seen_ack    |= (if_ack | mem_ack | boot_ack);
        end
        check("gate_strobe", 32'(seen_strobe), 32'(0));
        check("gate_ack", 32'(seen_ack), 32'(0));
        if_req = 1'b0; mem_req = 1'b0;

        // boot_done rises during a boot write; a pending mem read follows it
        a_at = -1; b_at = -1; b_val = '0;
        drive(0, 1'b1, 16'h0040, 16'h4444, 1'b1);
        for (int c = 1; c <= 2 * LAT + 3; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin boot_done = 1'b1; drive(1, 1'b0, 16'h0040, 16'h0000, 1'b1); end
            if (a_at > 0) boot_wr = 1'b0;
            if (b_at > 0) mem_req = 1'b0;
            @(negedge clk);
            if (boot_ack) a_at = c;
            if (mem_ack) begin b_at = c; b_val = mem_rdata; end
        end
        boot_wr = 1'b0; mem_req = 1'b0;
        model_mem[32'h40] = 16'h4444;
        exp_mem_rdata = 16'h4444;
        check("bdry_boot_ack", a_at, LAT);
        check("bdry_mem_ack", b_at, 2 * LAT + 1);
        check("bdry_mem_rdata", 32'(b_val), 32'(16'h4444));

        // boot_wr after boot_done is ignored
        seen_strobe = 0; seen_ack = 0;
        boot_wr = 1'b1; boot_addr = 16'h0010; boot_data = 16'h0BAD;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            seen_strobe |= !ram_ce_n;
            seen_ack    |= (if_ack | mem_ack | boot_ack);
        end
        boot_wr = 1'b0;
        check("late_boot_strobe", 32'(seen_strobe), 32'(0));
        check("late_boot_ack", 32'(seen_ack), 32'(0));

        // Simultaneous mem and if: mem first, if one full transaction later
        txn("arb_w20", 1, 1'b1, 16'h0020, 16'h1111, 1'b0);
        txn("arb_w30", 1, 1'b1, 16'h0030, 16'h2222, 1'b0);
        a_at = -1; b_at = -1; a_val = '0; b_val = '0;
        drive(1, 1'b0, 16'h0020, 16'h0000, 1'b1);
        drive(2, 1'b0, 16'h0030, 16'h0000, 1'b1);
        for (int c = 1; c <= 2 * LAT + 3; c++) begin
            @(posedge clk); #1;
            if (a_at > 0) mem_req = 1'b0;
            if (b_at > 0) if_req = 1'b0;
            @(negedge clk);
            if (mem_ack) begin a_at = c; a_val = mem_rdata; end
            if (if_ack) begin b_at = c; b_val = if_rdata; end
        end
        mem_req = 1'b0; if_req = 1'b0;
        exp_mem_rdata = 16'h1111; exp_if_rdata = 16'h2222;
        check("arb_mem_ack", a_at, LAT);
        check("arb_if_ack", b_at, 2 * LAT + 1);
        check("arb_mem_rdata", 32'(a_val), 32'(16'h1111));
        check("arb_if_rdata", 32'(b_val), 32'(16'h2222));

        txn("top_read", 2, 1'b0, 16'hFFFF, 16'h0000, 1'b0);
        txn("drop_read", 1, 1'b0, 16'h0010, 16'h0000, 1'b1);

        // Randomized CPU traffic
        for (int k = 0; k < 40; k++) begin
            int port;
            logic we;
            port = $urandom_range(1, 2);
            we   = (port == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            txn("rand", port, we, pool[$urandom_range(0, 7)], 16'($urandom),
                $urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset during ACCESS of a mem write aborts it
        seen_ack = 0;
        drive(1, 1'b1, 16'h7777, 16'h1357, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1, 1'b1, 16'h7777, 16'h1357, 1'b0);
        @(negedge clk);
        check("abort_in_access", 32'(ram_ce_n), 32'(0));
        @(negedge clk);
        check("abort_strobe", 32'({ram_ce_n, ram_oe_n, ram_we_n, ram_dout_oe}), 32'(4'b1110));
        check("abort_busy_ack", 32'({busy, boot_ack, mem_ack, if_ack}), 32'(0));
        check("abort_rdata", 32'({if_rdata, mem_rdata}), 32'(0));
        rst = 1'b0;
        exp_mem_rdata = '0; exp_if_rdata = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            seen_ack |= (mem_ack | if_ack | boot_ack);
        end
        check("abort_no_ack", 32'(seen_ack), 32'(0));

        txn("post_rst_read", 1, 1'b0, 16'h0040, 16'h0000, 1'b0);
        txn("post_rst_if", 2, 1'b0, 16'h0020, 16'h0000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, the single system clock; all logic updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset, sampled on the clk rising edge.
REQ-003 SHALL have port boot_done, input, 1; high means the boot copy is finished and CPU ports are enabled.
REQ-004 SHALL have boot port signals: boot_wr (in, 1), the write request level; boot_addr (in, 16); boot_data (in, 16); boot_ack (out, 1), a completion pulse.
REQ-005 SHALL have instruction-fetch port signals: if_req (in, 1); if_addr (in, 16); if_rdata (out, 16); if_ack (out, 1), a completion pulse.
REQ-006 SHALL have data port signals: mem_req (in, 1); mem_we (in, 1); mem_addr (in, 16); mem_wdata (in, 16); mem_rdata (out, 16); mem_ack (out, 1), a completion pulse.
REQ-007 SHALL have SRAM signals: ram_addr (out, 18); ram_dout (out, 16); ram_din (in, 16); ram_dout_oe (out, 1), high to drive the bus; ram_ce_n, ram_oe_n and ram_we_n (out, 1 each, active low).
REQ-008 SHALL have port busy, output, 1; it is high in every state except IDLE.

Function
REQ-009 SHALL implement the FSM states IDLE, ACCESS, WAIT (present only with RAM_WAIT_EN) and DONE.
REQ-010 In IDLE, the block SHALL select the grant by fixed priority: boot (boot_wr and !boot_done), then mem (mem_req and boot_done), then if (if_req and boot_done).
REQ-011 On a grant, the block SHALL latch the address, write data and direction, then move to ACCESS.
REQ-012 The boot grant SHALL always be a write; the if grant SHALL always be a read; the mem grant direction SHALL be mem_we.
REQ-013 ram_addr SHALL be {2'b00, latched 16-bit address}; there is no wrap or offset.
REQ-014 In ACCESS and WAIT, ram_ce_n SHALL be 0.
REQ-015 In ACCESS and WAIT, a read SHALL set ram_oe_n=0 and ram_dout_oe=0; a write SHALL set ram_we_n=0, ram_dout_oe=1 and ram_dout equal to the latched data.
REQ-016 Read data SHALL be captured from ram_din on the last strobe cycle (ACCESS without RAM_WAIT_EN, WAIT with it) into the granted port's rdata register.
REQ-017 rdata registers SHALL hold their value until the next read completes on that port.
REQ-018 In DONE, all strobes SHALL be high and ram_dout_oe SHALL be 0.
REQ-019 In DONE, exactly the granted port's ack SHALL be 1 for that single cycle; the next state SHALL be IDLE.
REQ-020 Latency SHALL be: request seen in IDLE at cycle N -> ack in cycle N+2 without RAM_WAIT_EN, and in cycle N+3 with it.
REQ-021 The idle gap between back-to-back transactions SHALL be exactly one IDLE cycle.
REQ-022 A requester SHALL hold its request and operands until its ack; the latched copy is used regardless.
REQ-023 Dropping a request mid-transaction SHALL NOT abort it; the transaction completes and the ack still pulses.
REQ-024 CPU requests while boot_done=0 SHALL be ignored: no strobe and no ack.
REQ-025 boot_wr while boot_done=1 SHALL be ignored.
REQ-026 If boot_done rises mid-transaction, the current boot write SHALL complete normally.
REQ-027 Simultaneous mem_req and if_req SHALL serve mem first; if is served on the next IDLE if if_req is still held.
REQ-028 Starvation of if by continuous mem traffic is accepted behaviour.
REQ-029 Strobes SHALL be registered outputs and SHALL never glitch low outside ACCESS/WAIT.

Reset
REQ-030 With rst=1 at a clk edge, the FSM SHALL go to IDLE.
REQ-031 Under reset, the outputs SHALL be: ram_ce_n=ram_oe_n=ram_we_n=1, ram_dout_oe=0, ram_addr=0, ram_dout=0, if_rdata=mem_rdata=0, all acks=0, busy=0.
REQ-032 Reset mid-transaction SHALL abort the transaction with no ack; strobes SHALL be high from the following cycle.

Configuration
REQ-033 With macro RAM_WAIT_EN defined, the WAIT state SHALL be compiled in, giving a two-cycle strobe for slow SRAM.
REQ-034 Without RAM_WAIT_EN, WAIT SHALL be absent and the strobe SHALL be one cycle, ACCESS->DONE.

Verification
REQ-035 Boot write test: boot_done=0, boot_wr=1, boot_addr=16'h0010, boot_data=16'hABCD -> ram_addr=18'h00010, ram_we_n=0, ram_dout=16'hABCD for one cycle; boot_ack at N+2.
REQ-036 Gating test: boot_done=0, if_req=1 for 10 cycles -> ram_ce_n stays 1 and if_ack stays 0.
REQ-037 Arbitration test: boot_done=1, mem_req=1 (mem_we=0, mem_addr=16'h0020) and if_req=1 (if_addr=16'h0030) in the same cycle, with SRAM model values [0x20]=16'h1111 and [0x30]=16'h2222 -> mem_ack with mem_rdata=16'h1111 first, then if_ack exactly 3 cycles later with if_rdata=16'h2222.
REQ-038 Reset abort test: rst=1 during ACCESS of a mem write -> no mem_ack, strobes high the next cycle, busy=0.
REQ-039 Wait-state test: with RAM_WAIT_EN, an if read of 16'hFFFF -> ram_addr=18'h0FFFF, ram_oe_n=0 for 2 cycles, if_ack at N+3.
REQ-040 Boundary test: boot_done rises during a boot write -> boot_ack still pulses; a pending mem_req is granted at the next IDLE.
